// File: rtl/nnlayer_mac_pipe.sv
// Signed multiply-accumulate pipeline: NUM_STAGE product stages feeding a saturating
// full-precision accumulator, with framed output rescaled and clamped to DOUT_WIDTH.
module nnlayer_mac_pipe #(
  parameter int unsigned DIN_WIDTH  = 14,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned DOUT_WIDTH = 14,
  parameter int unsigned NUM_STAGE  = 4,
  parameter int unsigned FRAC_BITS  = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic signed [DIN_WIDTH-1:0]  din0,
  input  logic signed [DIN_WIDTH-1:0]  din1,
  input  logic                         first,
  input  logic                         last,
  output logic                         out_valid,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         acc_ovf
);

  localparam int unsigned PW = 2 * DIN_WIDTH;

  localparam logic signed [ACC_WIDTH-1:0] AccMax = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] AccMin = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  // DOUT limits expressed at accumulator width for the clamp comparison
  localparam logic signed [ACC_WIDTH-1:0] DoutMaxA =
      {{(ACC_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] DoutMinA = ~DoutMaxA;
  localparam logic signed [DOUT_WIDTH-1:0] DoutMax = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [DOUT_WIDTH-1:0] DoutMin = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

  logic signed [PW-1:0]          a_ext, b_ext, prod;
  logic [NUM_STAGE-1:0][PW-1:0]  prod_q;
  logic [NUM_STAGE-1:0]          vld_q, fst_q, lst_q;

  logic signed [ACC_WIDTH-1:0]   acc_q, acc_new, p_ext, shifted;
  logic signed [ACC_WIDTH:0]     sum;
  logic                          ovf_q, ovf_new, acc_sat, dout_hi, dout_lo;
  logic signed [DOUT_WIDTH-1:0]  dout_new;
  logic                          top_vld, top_fst, top_lst;

  assign a_ext = $signed({{DIN_WIDTH{din0[DIN_WIDTH-1]}}, din0});
  assign b_ext = $signed({{DIN_WIDTH{din1[DIN_WIDTH-1]}}, din1});
  assign prod  = a_ext * b_ext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_q <= '0;
      vld_q  <= '0;
      fst_q  <= '0;
      lst_q  <= '0;
    end else if (ce) begin
      prod_q <= {prod_q[NUM_STAGE-2:0], prod};
      vld_q  <= {vld_q[NUM_STAGE-2:0], in_valid};
      fst_q  <= {fst_q[NUM_STAGE-2:0], in_valid & first};
      lst_q  <= {lst_q[NUM_STAGE-2:0], in_valid & last};
    end
  end

  assign top_vld = vld_q[NUM_STAGE-1];
  assign top_fst = fst_q[NUM_STAGE-1];
  assign top_lst = lst_q[NUM_STAGE-1];

  always_comb begin
    p_ext   = ACC_WIDTH'($signed(prod_q[NUM_STAGE-1]));
    sum     = {acc_q[ACC_WIDTH-1], acc_q} + {p_ext[ACC_WIDTH-1], p_ext};
    // Overflow shows as disagreement between the guard bit and the sign bit
    acc_sat = sum[ACC_WIDTH] != sum[ACC_WIDTH-1];
    if (top_fst) begin
      acc_new = p_ext;
      ovf_new = 1'b0;
    end else begin
      acc_new = acc_sat ? (sum[ACC_WIDTH] ? AccMin : AccMax) : sum[ACC_WIDTH-1:0];
      ovf_new = ovf_q | acc_sat;
    end
    shifted = acc_new >>> FRAC_BITS;
    dout_hi = shifted > DoutMaxA;
    dout_lo = shifted < DoutMinA;
    if (dout_hi)      dout_new = DoutMax;
    else if (dout_lo) dout_new = DoutMin;
    else              dout_new = shifted[DOUT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
      dout      <= '0;
      acc_ovf   <= 1'b0;
    end else if (ce) begin
      out_valid <= top_vld & top_lst;
      if (top_vld) begin
        acc_q <= acc_new;
        ovf_q <= ovf_new;
        if (top_lst) begin
          dout    <= dout_new;
          acc_ovf <= ovf_new | dout_hi | dout_lo;
        end
      end
    end
  end

endmodule

// File: tb/tb_nnlayer_mac_pipe.sv
// Directed bench for nnlayer_mac_pipe across three parameter sets, checked against a
// frame-level arithmetic model every cycle plus hand-computed literal expectations.
module tb_nnlayer_mac_pipe;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ce = 1'b1;
  logic in_valid = 1'b0;
  logic first = 1'b0;
  logic last = 1'b0;
  logic signed [13:0] din0 = '0;
  logic signed [13:0] din1 = '0;

  logic ov0, ov1, ov2, of0, of1, of2;
  logic signed [13:0] d0, d2;
  logic signed [27:0] d1;

  int ncmp = 0;
  int nfail = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  nnlayer_mac_pipe #(.FRAC_BITS(0)) u_f0 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .first(first), .last(last), .out_valid(ov0), .dout(d0), .acc_ovf(of0)
  );
  nnlayer_mac_pipe #(.ACC_WIDTH(28), .DOUT_WIDTH(28), .FRAC_BITS(0)) u_a28 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .first(first), .last(last), .out_valid(ov1), .dout(d1), .acc_ovf(of1)
  );
  nnlayer_mac_pipe u_def (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
    .first(first), .last(last), .out_valid(ov2), .dout(d2), .acc_ovf(of2)
  );

  function automatic bit get_v(input int i);
    return (i == 0) ? ov0 : (i == 1) ? ov1 : ov2;
  endfunction
  function automatic int get_d(input int i);
    return (i == 0) ? int'(d0) : (i == 1) ? int'(d1) : int'(d2);
  endfunction
  function automatic bit get_o(input int i);
    return (i == 0) ? of0 : (i == 1) ? of1 : of2;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    ncmp++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Model: frame arithmetic on longints, results released NUM_STAGE ce-edges after
  // the sampling edge of the last beat.
  localparam int Lat = 4;
  typedef struct packed {
    int              t;
    logic [2:0][31:0] d;
    logic [2:0]      o;
  } pend_t;

  int     aw [3] = '{32, 28, 32};
  int     dw [3] = '{14, 28, 14};
  int     fb [3] = '{0, 0, 6};
  longint macc [3];
  bit     movf [3];
  int     cecnt = 0;
  pend_t  pq [$];
  bit     exp_v = 1'b0;
  int     exp_d [3] = '{0, 0, 0};
  bit     exp_o [3] = '{0, 0, 0};

  function automatic longint clamp(input longint x, input int w, output bit s);
    longint one = 1;
    longint hi = (one <<< (w - 1)) - 1;
    longint lo = -(one <<< (w - 1));
    s = (x > hi) || (x < lo);
    return (x > hi) ? hi : (x < lo) ? lo : x;
  endfunction

  task automatic model_clear();
    pq.delete();
    exp_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      macc[i] = 0; movf[i] = 1'b0; exp_d[i] = 0; exp_o[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    pend_t e;
    longint p, sh, dd;
    bit s;
    if (!reset || !ce) return;
    cecnt++;
    exp_v = 1'b0;
    if (pq.size() != 0 && pq[0].t == cecnt) begin
      e = pq.pop_front();
      exp_v = 1'b1;
      for (int i = 0; i < 3; i++) begin
        exp_d[i] = $signed(e.d[i]);
        exp_o[i] = e.o[i];
      end
    end
    if (in_valid) begin
      e = '0;
      e.t = cecnt + Lat;
      for (int i = 0; i < 3; i++) begin
        p = longint'(din0) * longint'(din1);
        if (first) begin
          macc[i] = p;
          movf[i] = 1'b0;
        end else begin
          macc[i] = clamp(macc[i] + p, aw[i], s);
          movf[i] = movf[i] | s;
        end
        sh = macc[i] >>> fb[i];
        dd = clamp(sh, dw[i], s);
        e.d[i] = 32'(dd);
        e.o[i] = movf[i] | s;
      end
      if (last) pq.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d out_valid @%0t", i, $time), int'(get_v(i)), int'(exp_v));
        chk($sformatf("u%0d dout @%0t", i, $time), get_d(i), exp_d[i]);
        chk($sformatf("u%0d acc_ovf @%0t", i, $time), int'(get_o(i)), int'(exp_o[i]));
      end
    end
  end

  task automatic beat(input bit v, input int a, input int b, input bit f, input bit l);
    in_valid = v;
    din0 = 14'(a);
    din1 = 14'(b);
    first = f;
    last = l;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    beat(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic wait_out(input int idx, input int start, output int lat);
    lat = start;
    while (!get_v(idx) && lat < 30) begin
      idle();
      lat++;
    end
  endtask

  int lat, pulses;

  initial begin
    model_clear();
    #12;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset u%0d out_valid", i), int'(get_v(i)), 0);
      chk($sformatf("reset u%0d dout", i), get_d(i), 0);
      chk($sformatf("reset u%0d acc_ovf", i), int'(get_o(i)), 0);
    end
    #8 reset = 1'b1;
    cmp_en = 1'b1;

    // Three-beat frame
    beat(1, 100, 2, 1, 0);
    beat(1, -50, 4, 0, 0);
    beat(1, 7, 3, 0, 1);
    wait_out(0, 1, lat);
    chk("t1 latency", lat, 5);
    chk("t1 u0 dout", get_d(0), 21);
    chk("t1 u0 ovf", int'(get_o(0)), 0);
    chk("t1 u2 dout", get_d(2), 0);

    // Single-beat frames hitting the DOUT clamp
    beat(1, 8191, 8191, 1, 1);
    wait_out(0, 1, lat);
    chk("t2a u0 dout", get_d(0), 8191);
    chk("t2a u0 ovf", int'(get_o(0)), 1);
    chk("t2a u1 dout", get_d(1), 67092481);
    chk("t2a u1 ovf", int'(get_o(1)), 0);
    beat(1, -8192, 8191, 1, 1);
    wait_out(0, 1, lat);
    chk("t2b u0 dout", get_d(0), -8192);
    chk("t2b u0 ovf", int'(get_o(0)), 1);

    // Accumulator saturation on the 28-bit instance, then clean frame
    beat(1, 8191, 8191, 1, 0);
    beat(1, 8191, 8191, 0, 0);
    beat(1, 8191, 8191, 0, 1);
    wait_out(1, 1, lat);
    chk("t3 u1 dout", get_d(1), 134217727);
    chk("t3 u1 ovf", int'(get_o(1)), 1);
    beat(1, 1, 1, 1, 1);
    wait_out(1, 1, lat);
    chk("t3 next u1 dout", get_d(1), 1);
    chk("t3 next u1 ovf", int'(get_o(1)), 0);

    // Default shift, back-to-back single-beat frames
    beat(1, 64, 3, 1, 1);
    beat(1, -1, 1, 1, 1);
    wait_out(2, 2, lat);
    chk("t4 latency", lat, 5);
    chk("t4 u2 dout a", get_d(2), 3);
    idle();
    chk("t4 second pulse", int'(get_v(2)), 1);
    chk("t4 u2 dout b", get_d(2), -1);
    idle();
    chk("t4 pulse end", int'(get_v(2)), 0);

    // ce stall with a frame in flight
    beat(1, 10, 10, 1, 0);
    beat(1, 5, 5, 0, 1);
    ce = 1'b0;
    for (int k = 0; k < 3; k++) idle();
    ce = 1'b1;
    wait_out(0, 4, lat);
    chk("t5 stalled latency", lat, 8);
    chk("t5 u0 dout", get_d(0), 125);

    // Reset with a frame in flight
    beat(1, 3, 3, 1, 1);
    idle();
    idle();
    #3;
    reset = 1'b0;
    model_clear();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t6 u%0d out_valid", i), int'(get_v(i)), 0);
      chk($sformatf("t6 u%0d dout", i), get_d(i), 0);
      chk($sformatf("t6 u%0d acc_ovf", i), int'(get_o(i)), 0);
    end
    @(posedge clk);
    #4 reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      idle();
      if (ov0) pulses++;
    end
    chk("t6 no output after reset", pulses, 0);

    // No first since reset, ignored invalid beat, mid-frame restart, continued last
    beat(0, 99, 99, 1, 1);
    beat(1, 2, 3, 0, 1);
    wait_out(0, 1, lat);
    chk("t7 u0 no-first dout", get_d(0), 6);
    beat(1, 5, 5, 1, 0);
    beat(1, 1, 1, 1, 1);
    wait_out(0, 1, lat);
    chk("t7 u0 restart dout", get_d(0), 1);
    beat(1, 2, 2, 0, 1);
    wait_out(0, 1, lat);
    chk("t7 u0 continue dout", get_d(0), 5);
    idle();
    idle();

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
